// File: rtl/debounce_fsm.sv
// Pushbutton conditioner: 2-flop synchronizer feeding a four-state debounce FSM.
// Produces a registered debounced level plus one-cycle press/release pulses.
module debounce_fsm #(
   parameter int   DEBOUNCE_CYCLES = 120000,
   parameter int   CNT_W           = 17,
   parameter logic ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1, sync2, s;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             level_nxt, rise_nxt, fall_nxt, busy_nxt;

   // Synchronizer idles at the released pin value so reset never looks like a press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= ACTIVE_LOW;
         sync2 <= ACTIVE_LOW;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   assign s = sync2 ^ ACTIVE_LOW;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         btn_level <= 1'b0;
         btn_rise  <= 1'b0;
         btn_fall  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         btn_level <= level_nxt;
         btn_rise  <= rise_nxt;
         btn_fall  <= fall_nxt;
         busy      <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = btn_level;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (s) begin
               state_nxt = WAIT_PRESS;
               cnt_nxt   = '0;
            end
         end
         WAIT_PRESS: begin
            if (!s) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
               level_nxt = 1'b1;
               rise_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!s) begin
               state_nxt = WAIT_RELEASE;
               cnt_nxt   = '0;
            end
         end
         WAIT_RELEASE: begin
            if (s) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               level_nxt = 1'b0;
               fall_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
      // busy tracks the state being entered so it lines up with the state register.
      busy_nxt = (state_nxt == WAIT_PRESS) || (state_nxt == WAIT_RELEASE);
   end

endmodule

// File: tb/tb_debounce_fsm.sv
// Bench for debounce_fsm: two instances (active-low and active-high pins), a run-length
// reference model per instance pushing expected outputs into a scoreboard queue.
module tb_debounce_fsm;

   localparam int N = 4;

   typedef logic [3:0] exp_t;  // {level, rise, fall, busy}

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst  [2];
   logic pin  [2];
   logic lvl  [2];
   logic rise [2];
   logic fall [2];
   logic bsy  [2];

   int checks = 0;
   int errors = 0;

   debounce_fsm #(.DEBOUNCE_CYCLES(N), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .reset(rst[0]), .btn_in(pin[0]),
      .btn_level(lvl[0]), .btn_rise(rise[0]), .btn_fall(fall[0]), .busy(bsy[0])
   );

   debounce_fsm #(.DEBOUNCE_CYCLES(N), .CNT_W(3), .ACTIVE_LOW(1'b0)) dut_ah (
      .clk(clk), .reset(rst[1]), .btn_in(pin[1]),
      .btn_level(lvl[1]), .btn_rise(rise[1]), .btn_fall(fall[1]), .busy(bsy[1])
   );

   task automatic check_out(string nm, exp_t act, exp_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: lvl/rise/fall/busy got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_int(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : ch
      localparam logic AL = 1'(g == 0);
      exp_t sb[$];
      int   run = 0;
      logic lvl_m = 1'b0;
      logic p1 = AL, p2 = AL;
      int   rise_cnt = 0;

      // Reference: the level flips once the synchronized pin has disagreed with it for
      // N+1 consecutive samples; busy means a disagreeing run is in progress.
      always @(posedge clk or posedge rst[g]) begin
         logic s, r, f, lvl_n;
         int   run_n;
         if (rst[g]) begin
            p1    <= AL;
            p2    <= AL;
            lvl_m <= 1'b0;
            run   <= 0;
            sb.delete();
         end else begin
            s     = p2 ^ AL;
            run_n = (s != lvl_m) ? run + 1 : 0;
            lvl_n = lvl_m;
            r     = 1'b0;
            f     = 1'b0;
            if (run_n == N + 1) begin
               lvl_n = s;
               r     = s;
               f     = !s;
               run_n = 0;
            end
            sb.push_back({lvl_n, r, f, (run_n > 0)});
            lvl_m <= lvl_n;
            run   <= run_n;
            p2    <= p1;
            p1    <= pin[g];
         end
      end

      always @(negedge clk) begin
         exp_t act, e;
         act = {lvl[g], rise[g], fall[g], bsy[g]};
         if (rise[g]) rise_cnt++;
         if (rst[g]) begin
            check_out($sformatf("reset_outputs_%0d", g), act, 4'b0000);
         end else if (sb.size() > 0) begin
            e = sb.pop_front();
            check_out($sformatf("scoreboard_%0d", g), act, e);
         end
      end
   end

   task automatic hold(int g, logic v, int n);
      pin[g] = v;
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int r0;
      rst[0] = 1'b1; rst[1] = 1'b1;
      pin[0] = 1'b0;            // active-low button held pressed through reset
      pin[1] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst[0] = 1'b0; rst[1] = 1'b0;

      r0 = ch[0].rise_cnt;
      hold(0, 1'b0, 12);
      check_int("held_reset_rise_count", ch[0].rise_cnt - r0, 1);
      check_int("held_reset_level", int'(lvl[0]), 1);
      hold(0, 1'b1, 12);
      check_int("release_level", int'(lvl[0]), 0);

      // clean press / release
      hold(0, 1'b0, 10);
      hold(0, 1'b1, 10);

      // glitch shorter than the qualification window
      r0 = ch[0].rise_cnt;
      hold(0, 1'b0, 3);
      hold(0, 1'b1, 10);
      check_int("glitch_rise_count", ch[0].rise_cnt - r0, 0);
      check_int("glitch_level", int'(lvl[0]), 0);

      // chatter then stable press
      r0 = ch[0].rise_cnt;
      hold(0, 1'b0, 2); hold(0, 1'b1, 2);
      hold(0, 1'b0, 2); hold(0, 1'b1, 2);
      hold(0, 1'b0, 12);
      check_int("chatter_rise_count", ch[0].rise_cnt - r0, 1);
      hold(0, 1'b1, 12);

      // active-high instance: press and release
      hold(1, 1'b1, 12);
      check_int("ah_press_level", int'(lvl[1]), 1);
      hold(1, 1'b0, 12);
      check_int("ah_release_level", int'(lvl[1]), 0);

      // reset while qualifying a press (counter at 2 after the fifth edge)
      r0 = ch[1].rise_cnt;
      hold(1, 1'b1, 5);
      check_int("ah_busy_before_reset", int'(bsy[1]), 1);
      rst[1] = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      pin[1] = 1'b0;
      rst[1] = 1'b0;
      hold(1, 1'b0, 12);
      check_int("ah_abort_rise_count", ch[1].rise_cnt - r0, 0);
      check_int("ah_abort_level", int'(lvl[1]), 0);

      // randomized bouncing on both pins
      for (int i = 0; i < 120; i++) begin
         pin[1] = 1'($urandom_range(0, 1));
         hold(0, 1'($urandom_range(0, 1)), $urandom_range(1, 10));
      end
      hold(0, 1'b1, 12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
